// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer codes and slave FSM states shared by the SRAM slave.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic       RESP_OKAY     = 1'b0;
    localparam logic       RESP_ERROR    = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;
endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// ahb_lite_sram_slave_if: AHB-Lite bus signals seen by a single slave.
interface ahb_lite_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    modport master (output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
                    input hreadyout, hresp, hrdata);
    modport slave (input hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
                   output hreadyout, hresp, hrdata);
endinterface

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: DEPTH x 32 storage, synchronous write, combinational read, cleared by reset.
module ahb_sram_array #(
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: word-only AHB-Lite SRAM slave with configurable wait states
// and ERROR responses for out-of-range or non-word accesses.
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WAIT_STATES = 0
) (
    input logic hclk,
    input logic hreset,
    ahb_lite_sram_slave_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = S_IDLE;
    localparam logic [1:0] WAIT = S_WAIT;
    localparam logic [1:0] ERR1 = S_ERR1;
    localparam logic [1:0] ERR2 = S_ERR2;
    localparam logic [2:0] WS = 3'(WAIT_STATES);
    logic [1:0]    state, nstate;
    logic [2:0]    cnt;
    logic [AW-1:0] idx;
    logic          wr, err, act;
    logic          acc, bad, done, we;
    logic [31:0]   rdata;
    assign acc = bus.hsel & bus.hready & bus.htrans[1];
    assign bad = (bus.haddr[31:2] >= 30'(DEPTH)) | (bus.hsize != HSIZE_WORD);
    assign bus.hreadyout = (state == IDLE) | (state == ERR2);
    assign bus.hresp = (state == ERR1) | (state == ERR2) ? RESP_ERROR : RESP_OKAY;
    // act marks a pending data phase; it completes on any cycle with hreadyout high
    assign done = act & bus.hreadyout;
    assign we = done & wr & ~err;
    assign bus.hrdata = done & ~wr & ~err ? rdata : '0;
    always_comb begin
        nstate = state == ERR1 ? ERR2 :
                 state == WAIT ? (cnt == 3'd0 ? IDLE : WAIT) :
                 ~acc          ? IDLE :
                 bad           ? ERR1 :
                 WS != 3'd0    ? WAIT : IDLE;
    end
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            wr    <= 1'b0;
            err   <= 1'b0;
            act   <= 1'b0;
        end else begin
            state <= nstate;
            cnt   <= state == WAIT ? cnt - 3'd1 : WS - 3'd1;
            if (bus.hreadyout) begin
                act <= acc;
                if (acc) begin
                    idx <= bus.haddr[AW+1:2];
                    wr  <= bus.hwrite;
                    err <= bad;
                end
            end
        end
    end
    ahb_sram_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk  (hclk),
        .rst  (hreset),
        .we   (we),
        .waddr(idx),
        .wdata(bus.hwdata),
        .raddr(idx),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: directed checks of a zero-wait and a three-wait SRAM slave.
module tb_ahb_lite_sram_slave;
    import ahb_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = HSIZE_WORD;
    logic [31:0] hwdata = '0;
    int          checks = 0;
    int          errors = 0;
    ahb_lite_sram_slave_if b0 ();
    ahb_lite_sram_slave_if b3 ();
    assign b0.hsel = hsel & ~sel;
    assign b3.hsel = hsel & sel;
    assign b0.haddr = haddr;
    assign b3.haddr = haddr;
    assign b0.htrans = htrans;
    assign b3.htrans = htrans;
    assign b0.hwrite = hwrite;
    assign b3.hwrite = hwrite;
    assign b0.hsize = hsize;
    assign b3.hsize = hsize;
    assign b0.hwdata = hwdata;
    assign b3.hwdata = hwdata;
    assign b0.hready = b0.hreadyout;
    assign b3.hready = b3.hreadyout;
    ahb_lite_sram_slave #(.DEPTH(16), .WAIT_STATES(0)) dut0 (.hclk(clk), .hreset(rst), .bus(b0));
    ahb_lite_sram_slave #(.DEPTH(16), .WAIT_STATES(3)) dut3 (.hclk(clk), .hreset(rst), .bus(b3));
    logic        ready, resp;
    logic [31:0] rdata;
    assign ready = sel ? b3.hreadyout : b0.hreadyout;
    assign resp  = sel ? b3.hresp : b0.hresp;
    assign rdata = sel ? b3.hrdata : b0.hrdata;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] sz, output logic [31:0] rd, output int lows,
                        output logic rs);
        @(negedge clk);
        hsel = 1'b1; haddr = a; htrans = HTRANS_NONSEQ; hwrite = w; hsize = sz;
        @(posedge clk);
        @(negedge clk);
        hsel = 1'b0; htrans = HTRANS_IDLE; hsize = HSIZE_WORD; hwdata = wd;
        lows = 0;
        while (!ready && lows < 20) begin
            lows++;
            @(negedge clk);
        end
        if (lows >= 20) chk("timeout", 32'd1, 32'd0);
        rd = rdata;
        rs = resp;
    endtask
    logic [31:0] rd;
    int          lows;
    logic        rs;
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready0", 32'(b0.hreadyout), 32'd1);
        chk("rst_resp0", 32'(b0.hresp), 32'd0);
        chk("rst_rdata0", b0.hrdata, 32'd0);
        chk("rst_ready3", 32'(b3.hreadyout), 32'd1);
        // zero-wait write then read
        sel = 1'b0;
        xfer(1'b1, 32'h4, 32'h11111111, HSIZE_WORD, rd, lows, rs);
        chk("w4_lows", 32'(lows), 32'd0);
        chk("w4_resp", 32'(rs), 32'd0);
        xfer(1'b0, 32'h4, 32'h0, HSIZE_WORD, rd, lows, rs);
        chk("r4_data", rd, 32'h11111111);
        chk("r4_lows", 32'(lows), 32'd0);
        chk("r4_resp", 32'(rs), 32'd0);
        // pipelined write 0x8 followed immediately by read 0x8
        @(negedge clk);
        hsel = 1'b1; haddr = 32'h8; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hwdata = 32'h22222222; haddr = 32'h8; hwrite = 1'b0;
        chk("b2b_wready", 32'(ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        hsel = 1'b0; htrans = HTRANS_IDLE;
        chk("b2b_rdata", rdata, 32'h22222222);
        chk("b2b_rready", 32'(ready), 32'd1);
        // out-of-range index 16 must not alias onto index 0
        xfer(1'b1, 32'h40, 32'hDEADBEEF, HSIZE_WORD, rd, lows, rs);
        chk("oor_lows", 32'(lows), 32'd1);
        chk("oor_resp", 32'(rs), 32'd1);
        xfer(1'b0, 32'h0, 32'h0, HSIZE_WORD, rd, lows, rs);
        chk("oor_alias", rd, 32'h0);
        chk("ok_after_err_resp", 32'(rs), 32'd0);
        // byte-size write is rejected and leaves memory untouched
        xfer(1'b1, 32'h4, 32'hBAD0BAD0, 3'b000, rd, lows, rs);
        chk("sz_lows", 32'(lows), 32'd1);
        chk("sz_resp", 32'(rs), 32'd1);
        xfer(1'b0, 32'h4, 32'h0, 3'b000, rd, lows, rs);
        chk("sz_rd_data", rd, 32'h0);
        chk("sz_rd_resp", 32'(rs), 32'd1);
        xfer(1'b0, 32'h4, 32'h0, HSIZE_WORD, rd, lows, rs);
        chk("sz_mem", rd, 32'h11111111);
        // BUSY with select, NONSEQ without select: no data phase
        @(negedge clk);
        hsel = 1'b1; haddr = 32'h4; htrans = HTRANS_BUSY; hwrite = 1'b1; hwdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        chk("busy_ready", 32'(ready), 32'd1);
        chk("busy_resp", 32'(resp), 32'd0);
        hsel = 1'b0; htrans = HTRANS_NONSEQ;
        @(posedge clk);
        @(negedge clk);
        chk("nosel_ready", 32'(ready), 32'd1);
        htrans = HTRANS_IDLE;
        @(posedge clk);
        xfer(1'b0, 32'h4, 32'h0, HSIZE_WORD, rd, lows, rs);
        chk("nodp_mem", rd, 32'h11111111);
        // three wait states
        sel = 1'b1;
        xfer(1'b1, 32'hC, 32'h55555555, HSIZE_WORD, rd, lows, rs);
        chk("ws_w_lows", 32'(lows), 32'd3);
        xfer(1'b0, 32'hC, 32'h0, HSIZE_WORD, rd, lows, rs);
        chk("ws_r_lows", 32'(lows), 32'd3);
        chk("ws_r_data", rd, 32'h55555555);
        chk("ws_r_resp", 32'(rs), 32'd0);
        // reset during WAIT of a write aborts it
        @(negedge clk);
        hsel = 1'b1; haddr = 32'h10; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hEEEEEEEE;
        chk("abort_wait", 32'(ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_resp", 32'(resp), 32'd0);
        xfer(1'b0, 32'h10, 32'h0, HSIZE_WORD, rd, lows, rs);
        chk("abort_mem", rd, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_lite_sram_slave.md
AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH SHALL default to 16 and SHALL set the memory depth in 32-bit words; it is a power of two, 4..256.
REQ-003 Parameter WAIT_STATES SHALL default to 0 and SHALL set the number of HREADYOUT-low cycles per OKAY data phase; range 0..7.
REQ-004 HCLK  in  1  bus clock; all state changes on the rising edge.
REQ-005 HRESET  in  1  synchronous active-high reset.
REQ-006 HSEL  in  1  slave select, qualifies the address phase.
REQ-007 HADDR  in  32  byte address; bits [1:0] ignored.
REQ-008 HTRANS  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 HWRITE  in  1  1 = write, 0 = read.
REQ-010 HSIZE  in  3  transfer size; only 3'b010 (word) is legal.
REQ-011 HWDATA  in  32  write data, valid in the data phase.
REQ-012 HREADY  in  1  bus-level ready, marks the end of the previous data phase.
REQ-013 HREADYOUT  out  1  slave ready; 0 = extend the data phase.
REQ-014 HRESP  out  1  0 = OKAY, 1 = ERROR.
REQ-015 HRDATA  out  32  read data, valid when HREADYOUT=1 in a read data phase.

Function
REQ-016 An address phase SHALL be accepted on an edge where HSEL=1, HREADY=1 and HTRANS[1]=1.
- On acceptance the block captures the word index HADDR[31:2], HWRITE and an error flag.
- The error flag is set when the word index is >= DEPTH or HSIZE != 3'b010.
REQ-017 IDLE or BUSY transfers, and any cycle with HSEL=0, SHALL produce no data phase; HREADYOUT stays 1 and HRESP 0.
REQ-018 The FSM SHALL have four states: IDLE, WAIT, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0.
- An accepted OKAY transfer goes to WAIT when WAIT_STATES>0, otherwise the block stays in IDLE for a zero-wait data phase.
- An accepted erroring transfer goes to ERR1.
REQ-019 WAIT SHALL hold HREADYOUT=0 for exactly WAIT_STATES cycles, counted by a 3-bit down-counter.
- The following cycle has HREADYOUT=1, completing the data phase.
- If a new transfer is accepted on that completing edge, the FSM re-enters WAIT or ERR1 accordingly; otherwise it returns to IDLE.
REQ-020 ERR1 SHALL drive HREADYOUT=0, HRESP=1 for one cycle.
- ERR2 SHALL drive HREADYOUT=1, HRESP=1 for one cycle, then the FSM follows the REQ-019 next-transfer rule.
- An erroring transfer SHALL never modify memory and SHALL drive HRDATA=0.
REQ-021 A write SHALL commit HWDATA to mem[index] on the edge ending its OKAY data phase (HREADYOUT=1); no byte lanes are used.
REQ-022 A read SHALL drive HRDATA=mem[index] during the data-phase cycle with HREADYOUT=1; HRDATA SHALL be 0 outside read data phases.
REQ-023 Read-after-write to the same index in back-to-back transfers SHALL return the newly written data (write-through forwarding of HWDATA).
REQ-024 The word index SHALL NOT wrap: index >= DEPTH is an error, never aliased.
REQ-025 The data phase SHALL end only when HREADYOUT=1; capture of the next address phase is gated by HREADY.

Reset
REQ-026 HRESET=1 SHALL, on the next edge, set state IDLE, wait counter 0, captured controls cleared, HREADYOUT=1, HRESP=0, HRDATA=0, and all memory words to 0.
REQ-027 Reset asserted mid data phase (WAIT, ERR1 or ERR2) SHALL abort the transfer with no memory write.

Structure
REQ-028 Package ahb_pkg SHALL hold the HTRANS codes, HSIZE_WORD, the HRESP codes and the FSM state enum.
REQ-029 Sub-module ahb_sram_array SHALL implement the DEPTH x 32 storage with one synchronous write port and one combinational read port.

Verification
REQ-030 Reset, then write 0x11111111 to 0x00000004 and read 0x00000004 with WAIT_STATES=0 -> HRDATA=0x11111111, HREADYOUT never low, HRESP=0.
REQ-031 Back-to-back write 0x22222222 to 0x8 followed by a read of 0x8 -> the read returns 0x22222222.
REQ-032 WAIT_STATES=3: read 0xC after writing 0x55555555 -> HREADYOUT low for exactly 3 cycles, then 0x55555555 with HREADYOUT=1.
REQ-033 Access 0x40 (index 16, DEPTH=16) or HSIZE=3'b000 -> one cycle HREADYOUT=0/HRESP=1, then one cycle 1/1; memory unchanged.
REQ-034 HRESET asserted during WAIT of a write of 0xEEEEEEEE -> next cycle HREADYOUT=1, HRESP=0, and a subsequent read of that address returns 0.
REQ-035 HTRANS=BUSY with HSEL=1, and NONSEQ with HSEL=0 -> no data phase and no memory change.
